// File: rtl/disp_conf_frame_writer.sv
// Disparity/confidence frame writer.
// Packs four zero-extended {disp, conf} entries per 64-bit word and streams
// whole decimated frames to memory via an Avalon-MM write master, rotating
// through num_buffers frame buffers and pulsing frame_done per frame.
module disp_conf_frame_writer #(
  parameter int unsigned disp_bits        = 5,
  parameter int unsigned dec_frame_width  = 240,
  parameter int unsigned dec_frame_height = 240,
  parameter logic [31:0] base_addr        = 32'h0000_0000,
  parameter int unsigned num_buffers      = 2,
  localparam int unsigned BUF_W = (num_buffers > 1) ? $clog2(num_buffers) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [disp_bits+7:0]   disp_conf_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enable,
  output logic [31:0]            avm_address,
  output logic                   avm_write,
  output logic [63:0]            avm_writedata,
  output logic [7:0]             avm_byteenable,
  input  logic                   avm_waitrequest,
  output logic                   frame_done,
  output logic [BUF_W-1:0]       frame_buf_idx
);

  localparam int unsigned FRAME_WORDS = (dec_frame_width * dec_frame_height) / 4;
  localparam int unsigned FRAME_BYTES = dec_frame_width * dec_frame_height * 2;
  localparam int unsigned WORD_W      = $clog2(FRAME_WORDS + 1);

  // ST_FLUSH: last word of the frame sits in the output register; input is
  // held off so the next frame never shares a word with this one.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_lane;
  logic [WORD_W-1:0] r_word_idx;
  logic [BUF_W-1:0]  r_buf_idx;
  logic [47:0]       r_pack;
  logic              r_avm_write;
  logic [31:0]       r_avm_address;
  logic [63:0]       r_avm_writedata;
  logic              r_frame_done;
  logic [BUF_W-1:0]  r_frame_buf_idx;

  logic              w_out_free;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last_entry;
  logic              w_last_word;
  logic              w_last_word_load;
  logic              w_wr_accept;
  logic              w_last_accept;
  logic [15:0]       w_entry16;
  logic [63:0]       w_word;
  logic [31:0]       w_addr;
  logic [BUF_W-1:0]  w_buf_next;

  // Handshake and datapath decode
  always_comb begin
    w_out_free       = (!r_avm_write) || (!avm_waitrequest);
    w_in_ready       = (r_state == ST_RUN) && ((r_lane != 2'd3) || w_out_free);
    w_accept         = in_valid && w_in_ready;
    w_last_entry     = w_accept && (r_lane == 2'd3);
    w_last_word      = (r_word_idx == WORD_W'(FRAME_WORDS - 1));
    w_last_word_load = w_last_entry && w_last_word;
    w_wr_accept      = r_avm_write && (!avm_waitrequest);
    w_last_accept    = (r_state == ST_FLUSH) && w_wr_accept;
    w_entry16        = 16'(disp_conf_in);
    w_word           = {w_entry16, r_pack};
    w_addr           = base_addr
                     + (32'(r_buf_idx) * 32'(FRAME_BYTES))
                     + (32'(r_word_idx) << 32'd3);
    if (r_buf_idx == BUF_W'(num_buffers - 1)) begin
      w_buf_next = '0;
    end else begin
      w_buf_next = r_buf_idx + BUF_W'(1);
    end
  end

  // Next-state logic; enable only matters in IDLE and at the frame boundary
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_word_load) begin
          w_next_state = ST_FLUSH;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_wr_accept) begin
          if (enable) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_FLUSH;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Lane counter and pack register for lanes 0..2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lane <= 2'd0;
      r_pack <= 48'd0;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_pack[15:0]  <= w_entry16;
        2'd1:    r_pack[31:16] <= w_entry16;
        2'd2:    r_pack[47:32] <= w_entry16;
        default: r_pack        <= 48'd0;
      endcase
    end
  end

  // Word index within the frame; wraps to 0 once the last word is loaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_idx <= '0;
    end else if (w_last_entry) begin
      if (w_last_word) begin
        r_word_idx <= '0;
      end else begin
        r_word_idx <= r_word_idx + WORD_W'(1);
      end
    end
  end

  // Buffer rotation and frame_done pulse on acceptance of the last word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_idx       <= '0;
      r_frame_done    <= 1'b0;
      r_frame_buf_idx <= '0;
    end else begin
      r_frame_done <= w_last_accept;
      if (w_last_accept) begin
        r_frame_buf_idx <= r_buf_idx;
        r_buf_idx       <= w_buf_next;
      end
    end
  end

  // Avalon output register: load on lane-3 accept, hold while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avm_write     <= 1'b0;
      r_avm_address   <= base_addr;
      r_avm_writedata <= 64'd0;
    end else if (w_last_entry) begin
      r_avm_write     <= 1'b1;
      r_avm_address   <= w_addr;
      r_avm_writedata <= w_word;
    end else if (w_wr_accept) begin
      r_avm_write     <= 1'b0;
    end
  end

  assign in_ready       = w_in_ready;
  assign avm_write      = r_avm_write;
  assign avm_address    = r_avm_address;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = 8'hFF;
  assign frame_done     = r_frame_done;
  assign frame_buf_idx  = r_frame_buf_idx;

endmodule

// File: tb/tb_disp_conf_frame_writer.sv
// Scoreboard bench for disp_conf_frame_writer on a tiny 8x2 frame.
module tb_disp_conf_frame_writer;

  localparam int          DB   = 5;
  localparam int          FW   = 8;
  localparam int          FH   = 2;
  localparam int          NB   = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DB+7:0] disp_conf_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          enable = 1'b0;
  logic [31:0]   avm_address;
  logic          avm_write;
  logic [63:0]   avm_writedata;
  logic [7:0]    avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic          frame_done;
  logic [0:0]    frame_buf_idx;

  disp_conf_frame_writer #(
    .disp_bits(DB), .dec_frame_width(FW), .dec_frame_height(FH),
    .base_addr(BASE), .num_buffers(NB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .disp_conf_in(disp_conf_in),
    .in_valid(in_valid), .in_ready(in_ready), .enable(enable),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .frame_done(frame_done),
    .frame_buf_idx(frame_buf_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         wq[$];
  logic        fq[$];
  int          checks = 0;
  int          errors = 0;
  int          lane_m = 0;
  int          word_m = 0;
  logic        buf_m = 1'b0;
  logic [63:0] pack_m = '0;
  bit          use_table = 1'b0;
  logic [63:0] frame_a_words [0:3];
  int          stall_left = 0;
  logic [31:0] stall_addr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Offer one entry; on acceptance update the reference packing model.
  task automatic send_entry(input logic [4:0] d, input logic [7:0] c);
    int   n;
    bit   acc;
    wr_t  w;
    logic [15:0] e16;
    disp_conf_in = {d, c};
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      #1;
      if (in_ready) begin
        acc = 1'b1;
      end else if (lane_m != 0) begin
        chk("ready_low_only_lane3_stall",
            {63'd0, (lane_m == 3) && avm_write && avm_waitrequest}, 64'd1);
      end
      step();
      n++;
    end
    chk("entry_accept_timeout", {63'd0, acc}, 64'd1);
    if (acc) begin
      e16 = 16'({d, c});
      pack_m[lane_m*16 +: 16] = e16;
      if (lane_m == 3) begin
        w.addr = BASE + 32'(buf_m) * 32'(FW*FH*2) + 32'(word_m * 8);
        w.data = use_table ? frame_a_words[word_m] : pack_m;
        wq.push_back(w);
        word_m++;
        if (word_m == FW*FH/4) begin
          fq.push_back(buf_m);
          buf_m = ~buf_m;
          word_m = 0;
        end
      end
      lane_m = (lane_m + 1) % 4;
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((wq.size() != 0 || fq.size() != 0) && n < bound) begin
      step();
      n++;
    end
    chk("drain_outstanding", 64'(wq.size() + fq.size()), 64'd0);
  endtask

  // Slave model: stall a chosen address for stall_left cycles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && avm_write && avm_address == stall_addr) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: pops expected writes / frame_done and checks stall stability
  initial begin
    logic        prev_stall;
    logic        prev_fd;
    logic [31:0] prev_addr;
    logic [63:0] prev_data;
    wr_t         w;
    logic        eb;
    prev_stall = 1'b0;
    prev_fd = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        prev_fd = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_write_held", {63'd0, avm_write}, 64'd1);
          chk("stall_addr_stable", {32'd0, avm_address}, {32'd0, prev_addr});
          chk("stall_data_stable", avm_writedata, prev_data);
        end
        if (avm_write && !avm_waitrequest) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%h data=%h expected none",
                     avm_address, avm_writedata);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", {32'd0, avm_address}, {32'd0, w.addr});
            chk("wr_data", avm_writedata, w.data);
            chk("wr_byteenable", {56'd0, avm_byteenable}, 64'hFF);
          end
        end
        if (frame_done) begin
          chk("frame_done_single_cycle", {63'd0, prev_fd}, 64'd0);
          if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done actual=1 expected 0");
          end else begin
            eb = fq.pop_front();
            chk("frame_buf_idx", {63'd0, frame_buf_idx}, {63'd0, eb});
          end
        end
        prev_stall = avm_write && avm_waitrequest;
        prev_fd    = frame_done;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
      end
    end
  end

  // Stimulus
  initial begin
    frame_a_words[0] = 64'h0303_0202_0101_0000;
    frame_a_words[1] = 64'h0707_0606_0505_0404;
    frame_a_words[2] = 64'h0B0B_0A0A_0909_0808;
    frame_a_words[3] = 64'h0F0F_0E0E_0D0D_0C0C;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_avm_write", {63'd0, avm_write}, 64'd0);
    chk("rst_avm_address", {32'd0, avm_address}, {32'd0, BASE});
    chk("rst_avm_writedata", avm_writedata, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_frame_buf_idx", {63'd0, frame_buf_idx}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Frame A: buffer 0, back-to-back, hand-computed words
    enable = 1'b1;
    use_table = 1'b1;
    for (int i = 0; i < 16; i++) send_entry(5'(i), 8'(i));
    use_table = 1'b0;

    // Frame B: buffer 1, second word stalled for 5 cycles
    stall_addr = BASE + 32'h28;
    stall_left = 5;
    for (int i = 0; i < 16; i++) send_entry(5'(31 - i), 8'(8'hA0 + i));

    // Frame C: wraps to buffer 0, random input gaps, enable dropped at entry 5
    for (int i = 0; i < 16; i++) begin
      send_entry(5'(i * 3), 8'($urandom_range(0, 255)));
      if (i == 5) enable = 1'b0;
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end
    wait_drain(200);
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("idle_in_ready_low", {63'd0, in_ready}, 64'd0);
      step();
    end
    in_valid = 1'b0;
    enable = 1'b1;

    // Frame D: buffer 1, first word stalled, then reset mid-word
    stall_addr = BASE + 32'h20;
    stall_left = 1000;
    for (int i = 0; i < 5; i++) send_entry(5'(i + 7), 8'(8'h50 + i));
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_avm_write", {63'd0, avm_write}, 64'd0);
    chk("async_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("async_rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("async_rst_avm_address", {32'd0, avm_address}, {32'd0, BASE});
    stall_left = 0;
    wq.delete();
    fq.delete();
    lane_m = 0;
    word_m = 0;
    buf_m = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Frame E: after reset, restarts at base_addr in buffer 0
    for (int i = 0; i < 16; i++) send_entry(5'(i), 8'(8'hFF - i));
    in_valid = 1'b0;
    wait_drain(200);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
